// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Requester 0 is the integer datapath and requester 1 is the branch/address unit.
//   Round-robin arbitration picks one requester. Its operation is latched into the op
//   registers and driven to the ALU for one cycle. The registered result is then returned
//   on a single response channel, tagged with the requester id.
//
// Ports:
//   CLOCK, RESET                  rising-edge clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op       request channel N (N = 0, 1), valid/ready handshake
//   resp_valid/ready              response handshake
//   resp_id/result/zero/err       response payload (requester id, ALU result, zero, illegal op)
//   alu_a, alu_b, alu_control     driven to the ALU from the op registers
//   alu_result, alu_zero          returned by the ALU
//
// Optional feature: when ALU_ARB_OPCHECK_EN is defined, an illegal opcode (above SLT) is
// still accepted, but it is not sent to the ALU. It completes with result 0, zero 1 and
// err 1. When the macro is undefined, opcodes go to the ALU unchecked and resp_err is 0.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_err_q, resp_err_d;

  logic             grant0, grant1, accept, sel;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OPW-1:0]   sel_op;

  // Grants are only issued in IDLE and never during the reset cycle. When both requesters
  // are valid, the grant goes to the one that was not granted last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !RESET) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  // A grant implies valid, so a grant is already a completed handshake.
  assign accept     = grant0 | grant1;
  assign sel        = grant1;
  assign sel_a      = sel ? req1_a  : req0_a;
  assign sel_b      = sel ? req1_b  : req0_b;
  assign sel_op     = sel ? req1_op : req0_op;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    err_d         = err_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d          = sel_a;
          b_d          = sel_b;
          id_d         = sel;
          last_grant_d = sel;
`ifdef ALU_ARB_OPCHECK_EN
          // Illegal opcodes are replaced by ADD so the ALU never sees them. The ALU result
          // is then ignored for this operation.
          err_d = (sel_op > OPW'(9));
          op_d  = err_d ? '0 : sel_op;
`else
          err_d = 1'b0;
          op_d  = sel_op;
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_err_d    = err_q;
        resp_result_d = err_q ? '0   : alu_result;
        resp_zero_d   = err_q ? 1'b1 : alu_zero;
        state_d       = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      err_q         <= err_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter.
// The bench contains its own ALU model, whose results are checked against hand-computed
// constants. Illegal opcodes return 32'hDEADBEEF, so an override of the result is visible.
module tb_alu_arbiter;
  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        resp_valid, resp_id, resp_zero, resp_err;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 CLOCK = ~CLOCK;

  always_comb begin
    case (alu_control)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = alu_a << alu_b[4:0];
      4'd6:    alu_result = alu_a >> alu_b[4:0];
      4'd7:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8:    alu_result = {31'b0, alu_a < alu_b};
      4'd9:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'b0);
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    @(negedge CLOCK);
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    n_tests++;
    if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_resp_flags: got %b want 0000",
                         {resp_valid, resp_id, resp_zero, resp_err});
    end
    n_tests++;
    if ({resp_result, alu_a, alu_b, alu_control} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0",
                         resp_result, alu_a, alu_b, alu_control);
    end
    tick();
    RESET = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Runs one operation from a single requester, with resp_ready held high.
  task automatic test_single_op(input string name, input bit id, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] op,
                                input logic [31:0] exp_res, input logic exp_zero);
    resp_ready = 1'b1;
    drive(id, a, b, op);
    @(negedge CLOCK);
    n_tests++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL %s_ready: got %b want %b", name, {req1_ready, req0_ready},
                         id ? 2'b10 : 2'b01);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLOCK);
    n_tests++;
    if ({resp_valid, alu_a, alu_b, alu_control} !== {1'b0, a, b, op}) begin
      n_fail++; $display("FAIL %s_exec: got v=%b %h %h %h want v=0 %h %h %h", name,
                         resp_valid, alu_a, alu_b, alu_control, a, b, op);
    end
    tick();
    @(negedge CLOCK);
    n_tests++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err} !==
        {1'b1, id, exp_res, exp_zero, 1'b0}) begin
      n_fail++; $display("FAIL %s_resp: got v=%b id=%b r=%h z=%b e=%b want v=1 id=%b r=%h z=%b e=0",
                         name, resp_valid, resp_id, resp_result, resp_zero, resp_err,
                         id, exp_res, exp_zero);
    end
    tick();
    @(negedge CLOCK);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: resp_valid got %b want 0", name, resp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] a0 [3] = '{32'd1, 32'hF0, 32'd1};
    logic [31:0] b0 [3] = '{32'd2, 32'hFF, 32'd31};
    logic [3:0]  o0 [3] = '{4'd0, 4'd4, 4'd5};
    logic [31:0] a1 [3] = '{32'h10, 32'd1, 32'hFFFFFFFF};
    logic [31:0] b1 [3] = '{32'h01, 32'd3, 32'd1};
    logic [3:0]  o1 [3] = '{4'd3, 4'd8, 4'd9};
    logic [31:0] exp_r [6] = '{32'd3, 32'h11, 32'h0F, 32'd1, 32'h80000000, 32'd1};
    int i0 = 0, i1 = 0, ng = 0, nr = 0, last_g = 0;
    bit gid;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nr < 6; cyc++) begin
      req0_valid = (i0 < 3);
      req1_valid = (i1 < 3);
      if (i0 < 3) drive(1'b0, a0[i0], b0[i0], o0[i0]);
      if (i1 < 3) drive(1'b1, a1[i1], b1[i1], o1[i1]);
      @(negedge CLOCK);
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        n_tests++;
        if ((req0_ready && req1_ready) || gid !== ng[0]) begin
          n_fail++; $display("FAIL rr_grant%0d: got ready=%b%b want id %0d", ng,
                             req1_ready, req0_ready, ng % 2);
        end
        if (ng > 0) begin
          n_tests++;
          if (cyc - last_g != 3) begin
            n_fail++; $display("FAIL rr_interval%0d: got %0d cycles want 3", ng, cyc - last_g);
          end
        end
        last_g = cyc;
        ng++;
        if (gid) i1++; else i0++;
      end
      if (resp_valid) begin
        n_tests++;
        if (nr > 5 || {resp_id, resp_result} !== {nr[0], exp_r[nr % 6]}) begin
          n_fail++; $display("FAIL rr_resp%0d: got id=%b r=%h want id=%0d r=%h", nr, resp_id,
                             resp_result, nr % 2, exp_r[nr % 6]);
        end
        nr++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++;
    if (nr != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d responses want 6", nr);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    drive(1'b0, 32'h80000000, 32'd4, 4'd7);
    @(negedge CLOCK);
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: req0_ready got %b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 4'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK);
      n_tests++;
      if ({resp_valid, resp_id, resp_result, resp_zero, req0_ready, req1_ready} !==
          {1'b1, 1'b0, 32'hF8000000, 1'b0, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b id=%b r=%h z=%b rdy=%b%b want v=1 id=0 r=f8000000 z=0 rdy=00",
                           k, resp_valid, resp_id, resp_result, resp_zero, req1_ready, req0_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    @(negedge CLOCK);
    n_tests++;
    if ({resp_valid, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_idle: got v=%b req1_ready=%b want v=0 ready=1",
                         resp_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge CLOCK);
    n_tests++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, 32'd2}) begin
      n_fail++; $display("FAIL bp_next: got v=%b id=%b r=%h want v=1 id=1 r=2",
                         resp_valid, resp_id, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    for (int n = 0; n < 2; n++) begin
      bit id = (n == 0);
      resp_ready = 1'b1;
      drive(id, 32'd3, 32'd4, 4'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      RESET = 1'b1;
      @(negedge CLOCK);
      n_tests++;
      if (alu_a !== 32'd3) begin
        n_fail++; $display("FAIL rst_exec%0d_alu: got %h want 3", n, alu_a);
      end
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge CLOCK);
      n_tests++;
      if ({resp_valid, resp_id, resp_result, resp_zero, alu_a, alu_control,
           req0_ready, req1_ready} !== 72'b0) begin
        n_fail++; $display("FAIL rst_exec%0d_clear: got v=%b id=%b r=%h z=%b a=%h op=%h rdy=%b%b want all 0",
                           n, resp_valid, resp_id, resp_result, resp_zero, alu_a, alu_control,
                           req1_ready, req0_ready);
      end
      tick();
      RESET = 1'b0;
      @(negedge CLOCK);
      n_tests++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
        n_fail++; $display("FAIL rst_exec%0d_tie: got %b want 01", n, {req1_ready, req0_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        @(negedge CLOCK);
        n_tests++;
        if (resp_valid !== 1'b0) begin
          n_fail++; $display("FAIL rst_exec%0d_noresp%0d: got %b want 0", n, k, resp_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_opcheck();
    resp_ready = 1'b1;
    drive(1'b0, 32'd5, 32'd3, 4'b1100);
    tick();
    req0_valid = 1'b0;
    @(negedge CLOCK);
    n_tests++;
`ifdef ALU_ARB_OPCHECK_EN
    if (alu_control !== 4'b0000) begin
      n_fail++; $display("FAIL opchk_ctrl: got %b want 0000", alu_control);
    end
`else
    if (alu_control !== 4'b1100) begin
      n_fail++; $display("FAIL opchk_ctrl: got %b want 1100", alu_control);
    end
`endif
    tick();
    @(negedge CLOCK);
    n_tests++;
`ifdef ALU_ARB_OPCHECK_EN
    if ({resp_valid, resp_err, resp_result, resp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL opchk_resp: got v=%b e=%b r=%h z=%b want v=1 e=1 r=0 z=1",
                         resp_valid, resp_err, resp_result, resp_zero);
    end
`else
    if ({resp_valid, resp_err, resp_result, resp_zero} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL opchk_resp: got v=%b e=%b r=%h z=%b want v=1 e=0 r=deadbeef z=0",
                         resp_valid, resp_err, resp_result, resp_zero);
    end
`endif
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op("add", 1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0);
    test_single_op("sub", 1'b1, 32'd9, 32'd9, 4'd1, 32'd0, 1'b1);
    test_single_op("and", 1'b0, 32'hF0F0, 32'h0FF0, 4'd2, 32'h00F0, 1'b0);
    test_single_op("srl", 1'b1, 32'h80000000, 32'd31, 4'd6, 32'd1, 1'b0);
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_opcheck();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
